// File: rtl/inter_packet_gap_monitor_if.sv
// AXI-Stream bundle used on both sides of the inter-packet gap monitor.
interface inter_packet_gap_monitor_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/inter_packet_gap_monitor.sv
// Measures idle cycles between AXI-Stream packets, stamps the gap into the SOP beat's tuser and keeps
// gap statistics. Define IPG_STATS_MINMAX_EN to build the gap_min/gap_max trackers.
module inter_packet_gap_monitor #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_GAP_TUSER_POS      = 96
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  inter_packet_gap_monitor_if.slave     s_axis,
  inter_packet_gap_monitor_if.master    m_axis,
  input  logic                          sw_rst,
  input  logic                          ipg_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0] gap_last,
  output logic [C_S_AXI_DATA_WIDTH-1:0] gap_min,
  output logic [C_S_AXI_DATA_WIDTH-1:0] gap_max,
  output logic [C_S_AXI_DATA_WIDTH-1:0] pkt_count
);
  localparam int GW = C_S_AXI_DATA_WIDTH;
  localparam logic [GW-1:0] GAP_ONES = {GW{1'b1}};
  localparam logic [GW-1:0] GAP_ONE  = {{(GW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_FIRST = 2'd0, ST_IN_PKT = 2'd1, ST_GAP = 2'd2} state_t;

  state_t                            state_r, state_s;
  logic [GW-1:0]                     gap_cnt_r, gap_cnt_s;
  logic [GW-1:0]                     gap_last_r, pkt_count_r;
  logic                              m_tvalid_r, m_tlast_r;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    m_tdata_r;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_tstrb_r;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_tuser_r;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_s;
  logic                              accept_s, sop_s, eop_s;

  assign s_axis.tready = m_axis.tready | ~m_tvalid_r;
  assign accept_s      = s_axis.tvalid & s_axis.tready;
  assign sop_s         = accept_s & (state_r != ST_IN_PKT);
  assign eop_s         = accept_s & s_axis.tlast;

  assign m_axis.tvalid = m_tvalid_r;
  assign m_axis.tlast  = m_tlast_r;
  assign m_axis.tdata  = m_tdata_r;
  assign m_axis.tstrb  = m_tstrb_r;
  assign m_axis.tuser  = m_tuser_r;
  assign gap_last      = gap_last_r;
  assign pkt_count     = pkt_count_r;

  // Packet-framing FSM next state; a single-beat packet goes straight back to GAP.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FIRST, ST_GAP: begin
        if (accept_s) state_s = s_axis.tlast ? ST_GAP : ST_IN_PKT;
        else          state_s = state_r;
      end
      ST_IN_PKT: begin
        if (eop_s) state_s = ST_GAP;
        else       state_s = state_r;
      end
      default: state_s = ST_FIRST;
    endcase
  end

  // Gap counter: restarts at each EOP handshake, counts idle cycles in GAP, sticks at all-ones.
  always_comb begin
    gap_cnt_s = gap_cnt_r;
    if (eop_s)                                         gap_cnt_s = '0;
    else if (state_r == ST_GAP && gap_cnt_r != GAP_ONES) gap_cnt_s = gap_cnt_r + GAP_ONE;
    else                                               gap_cnt_s = gap_cnt_r;
  end

  // Stamp selection; a beat taken during sw_rst sees the post-reset (no previous packet) stamp.
  always_comb begin
    tuser_s = s_axis.tuser;
    if (sw_rst) begin
      if (ipg_en) tuser_s[C_GAP_TUSER_POS +: GW] = GAP_ONES;
      else        tuser_s = s_axis.tuser;
    end else if (sop_s && ipg_en) begin
      tuser_s[C_GAP_TUSER_POS +: GW] = (state_r == ST_FIRST) ? GAP_ONES : gap_cnt_r;
    end else begin
      tuser_s = s_axis.tuser;
    end
  end

  // FSM state and gap counter registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r   <= ST_FIRST;
      gap_cnt_r <= '0;
    end else if (sw_rst) begin
      state_r   <= ST_FIRST;
      gap_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      gap_cnt_r <= gap_cnt_s;
    end
  end

  // Single output stage; holds while downstream stalls.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= '0;
      m_tstrb_r  <= '0;
      m_tuser_r  <= '0;
    end else if (sw_rst && !accept_s) begin
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tdata_r  <= '0;
      m_tstrb_r  <= '0;
      m_tuser_r  <= '0;
    end else if (accept_s) begin
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= s_axis.tlast;
      m_tdata_r  <= s_axis.tdata;
      m_tstrb_r  <= s_axis.tstrb;
      m_tuser_r  <= tuser_s;
    end else if (s_axis.tready) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  // Last-gap and packet-count statistics; the first packet after reset has no gap to report.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      gap_last_r  <= '0;
      pkt_count_r <= '0;
    end else if (sw_rst) begin
      gap_last_r  <= '0;
      pkt_count_r <= '0;
    end else begin
      if (sop_s && state_r == ST_GAP) gap_last_r <= gap_cnt_r;
      else                            gap_last_r <= gap_last_r;
      if (sop_s) pkt_count_r <= pkt_count_r + GAP_ONE;
      else       pkt_count_r <= pkt_count_r;
    end
  end

`ifdef IPG_STATS_MINMAX_EN
  logic [GW-1:0] gap_min_r, gap_max_r;

  assign gap_min = gap_min_r;
  assign gap_max = gap_max_r;

  // Unsigned min/max over every measured gap.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      gap_min_r <= GAP_ONES;
      gap_max_r <= '0;
    end else if (sw_rst) begin
      gap_min_r <= GAP_ONES;
      gap_max_r <= '0;
    end else if (sop_s && state_r == ST_GAP) begin
      if (gap_cnt_r < gap_min_r) gap_min_r <= gap_cnt_r;
      else                       gap_min_r <= gap_min_r;
      if (gap_cnt_r > gap_max_r) gap_max_r <= gap_cnt_r;
      else                       gap_max_r <= gap_max_r;
    end else begin
      gap_min_r <= gap_min_r;
      gap_max_r <= gap_max_r;
    end
  end
`else
  assign gap_min = '0;
  assign gap_max = '0;
`endif

endmodule

// File: tb/tb_inter_packet_gap_monitor.sv
// Scoreboard bench for inter_packet_gap_monitor: gaps are derived from handshake cycle numbers.
module tb_inter_packet_gap_monitor;
  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int GW  = 32;
  localparam int POS = 96;
  localparam int SW  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst = 1'b0;
  logic          ipg_en = 1'b1;
  logic [GW-1:0] gap_last, gap_min, gap_max, pkt_count;

  inter_packet_gap_monitor_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  inter_packet_gap_monitor_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  inter_packet_gap_monitor dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .sw_rst      (sw_rst),
    .ipg_en      (ipg_en),
    .gap_last    (gap_last),
    .gap_min     (gap_min),
    .gap_max     (gap_max),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  beat_t exp_q[$];
  bit    rand_ready = 1'b0;

  // Reference model: packet-level view with handshake cycle stamps.
  int            cyc = 0;
  bit            mdl_first = 1'b1;
  bit            mdl_in_pkt = 1'b0;
  int            mdl_eop_cyc = 0;
  logic [GW-1:0] mdl_last = '0, mdl_min = '1, mdl_max = '0, mdl_cnt = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    mdl_first  = 1'b1;
    mdl_in_pkt = 1'b0;
    mdl_last   = '0;
    mdl_min    = '1;
    mdl_max    = '0;
    mdl_cnt    = '0;
  endfunction

  function automatic void model_accept();
    beat_t         b;
    logic [GW-1:0] g;
    b = {s_if.tdata, s_if.tstrb, s_if.tuser, s_if.tlast};
    if (!mdl_in_pkt) begin
      if (mdl_first) begin
        g = '1;
      end else begin
        g = GW'(cyc - mdl_eop_cyc - 1);
        mdl_last = g;
        if (g < mdl_min) mdl_min = g;
        if (g > mdl_max) mdl_max = g;
      end
      if (ipg_en) b.user[POS +: GW] = g;
      mdl_cnt   = mdl_cnt + 1;
      mdl_first = 1'b0;
    end
    mdl_in_pkt = !s_if.tlast;
    if (s_if.tlast) mdl_eop_cyc = cyc;
    exp_q.push_back(b);
  endfunction

  // Monitor + scoreboard: handshakes are sampled on the falling edge before the rising edge that takes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast}, '0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast}, e);
        end
      end
      if (sw_rst) begin
        exp_q.delete();
        model_reset();
      end else if (s_if.tvalid && s_if.tready) begin
        model_accept();
      end
    end
    cyc++;
  end

  // Downstream ready: always 1, or random when backpressure is enabled.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input logic last, input bit a5);
    bit acc;
    s_if.tdata  = {8{$urandom}};
    s_if.tstrb  = $urandom;
    s_if.tuser  = a5 ? {16{8'hA5}} : {4{$urandom}};
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (n > 1000) begin
        chk("beat_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int idle, input bit a5);
    for (int i = 0; i < len; i++) send_beat(i == len - 1, a5);
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stats();
    @(negedge clk);
    chk("gap_last", gap_last, mdl_last);
    chk("pkt_count", pkt_count, mdl_cnt);
`ifdef IPG_STATS_MINMAX_EN
    chk("gap_min", gap_min, mdl_min);
    chk("gap_max", gap_max, mdl_max);
`else
    chk("gap_min_tied", gap_min, '0);
    chk("gap_max_tied", gap_max, '0);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    for (int n = 0; n < 2000 && (exp_q.size() != 0 || m_if.tvalid); n++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    check_stats();
  endtask

  task automatic pulse_sw_rst();
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_s_tready", s_if.tready, 1'b1);
    chk("rst_m_tdata", m_if.tdata, '0);
    chk("rst_gap_last", gap_last, '0);
    chk("rst_pkt_count", pkt_count, '0);
`ifdef IPG_STATS_MINMAX_EN
    chk("rst_gap_min", gap_min, 32'hFFFF_FFFF);
`else
    chk("rst_gap_min", gap_min, '0);
`endif
    chk("rst_gap_max", gap_max, '0);
    @(posedge clk);
    #1;

    // First packet, then exactly 10 idle cycles before the second.
    send_pkt(4, 9, 1'b0);
    check_stats();
    chk("first_pkt_count", pkt_count, 32'd1);
    send_pkt(4, 0, 1'b0);
    drain();
    chk("second_gap_last", gap_last, 32'd10);

    // Back-to-back single-beat packets after a soft reset.
    pulse_sw_rst();
    for (int i = 0; i < 3; i++) send_pkt(1, 0, 1'b0);
    drain();
    chk("b2b_pkt_count", pkt_count, 32'd3);
`ifdef IPG_STATS_MINMAX_EN
    chk("b2b_gap_min", gap_min, 32'd0);
`endif

    // Gaps 5, 2, 9 under random downstream backpressure.
    pulse_sw_rst();
    rand_ready = 1'b1;
    send_pkt(3, 5, 1'b0);
    send_pkt(3, 2, 1'b0);
    send_pkt(3, 9, 1'b0);
    send_pkt(3, 0, 1'b0);
    drain();

    // Stamping disabled: tuser passes through, stats still update.
    ipg_en = 1'b0;
    send_pkt(2, 3, 1'b1);
    send_pkt(2, 0, 1'b1);
    drain();
    ipg_en = 1'b1;

    // Randomised traffic.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      ipg_en = 1'($urandom_range(0, 1));
      send_pkt($urandom_range(1, 6), $urandom_range(0, 12), 1'b0);
      rand_ready = 1'b1;
    end
    drain();
    ipg_en = 1'b1;

    // Soft reset in the middle of a packet.
    send_beat(1'b0, 1'b0);
    send_beat(1'b0, 1'b0);
    sw_rst = 1'b1;
    @(negedge clk);
    chk("swrst_valid_before", m_if.tvalid, 1'b1);
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
    @(negedge clk);
    chk("swrst_valid_dropped", m_if.tvalid, 1'b0);
    chk("swrst_pkt_count", pkt_count, 32'd0);
    @(posedge clk);
    #1;
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b0);
    drain();
    chk("swrst_resume_count", pkt_count, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
